// File: rtl/fifo_4r.sv
// -----------------------------------------------------------------------------
// fifo_4r
//   Multi-pop FIFO with one write port and up to four pops per cycle,
//   first-word fall-through. The four oldest entries are presented
//   combinationally on packed lanes; the consumer chooses how many to take.
//   An empty FIFO forwards an accepted push straight to lane 0 (bypass), so a
//   producer/consumer pair can stream through it with zero added latency.
//
// Ports
//   clk         clock, all state updates on posedge
//   rst_n       synchronous reset, active-low
//   w_val       push w_data this cycle
//   w_data      push data
//   w_drop      push discarded because the FIFO is full (comb)
//   r_req       entries the consumer wants to pop, 0..4 (values >4 act as 4)
//   r_data_0..3 lane i = i-th oldest entry, all ones when lane not valid (comb)
//   r_vld       thermometer lane-valid mask, r_vld[i] = (i < avail) (comb)
//   r_cnt       entries actually popped = min(r_req, avail) (comb)
//   size        registered occupancy, 0..FIFO_DEPTH
//   full        registered, size == FIFO_DEPTH
//   data_avail  at least one lane valid (comb)
// -----------------------------------------------------------------------------
module fifo_4r #(
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_val,
  input  logic [FIFO_WIDTH-1:0] w_data,
  output logic                  w_drop,
  input  logic [2:0]            r_req,
  output logic [FIFO_WIDTH-1:0] r_data_0,
  output logic [FIFO_WIDTH-1:0] r_data_1,
  output logic [FIFO_WIDTH-1:0] r_data_2,
  output logic [FIFO_WIDTH-1:0] r_data_3,
  output logic [3:0]            r_vld,
  output logic [2:0]            r_cnt,
  output logic [CNT_WIDTH-1:0]  size,
  output logic                  full,
  output logic                  data_avail
);

  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int SUM_WIDTH = CNT_WIDTH + 1;
  localparam logic [FIFO_WIDTH-1:0] ELEM_NONE = '1;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Requests above four are treated as four.
  function automatic logic [2:0] clamp_req(input logic [2:0] req);
    return (req > 3'd4) ? 3'd4 : req;
  endfunction

  function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b);
    return (a < b) ? a : b;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  head;
  logic [PTR_WIDTH-1:0]  tail;

  logic                  w_acc;
  logic [2:0]            avail;
  logic [2:0]            req_eff;
  logic [SUM_WIDTH-1:0]  size_next;
  logic [PTR_WIDTH-1:0]  rd_ptr [4];
  logic [FIFO_WIDTH-1:0] lane   [4];
  logic                  empty;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  // Acceptance looks only at the registered full flag: a pop in the same cycle
  // does not free space for a push until the following cycle.
  assign w_acc  = w_val & ~full;
  assign w_drop = w_val &  full;
  assign empty  = (size == '0);

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------
  // With stored entries only storage is visible (at most four). When empty,
  // an accepted push is offered on lane 0 in the same cycle.
  always_comb begin
    avail = 3'd0;
    if (empty) begin
      avail = {2'b00, w_acc};
    end else if (size >= CNT_WIDTH'(4)) begin
      avail = 3'd4;
    end else begin
      avail = size[2:0];
    end
  end

  assign req_eff    = clamp_req(r_req);
  assign r_cnt      = min3(req_eff, avail);
  assign data_avail = (avail != 3'd0);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      r_vld[i] = (3'(i) < avail);
    end
  end

  // Lanes are masked to ELEM_NONE beyond avail so stale storage never leaks.
  // FIFO_DEPTH >= 8 keeps the four read pointers distinct.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_ptr[i] = head + PTR_WIDTH'(i);
      lane[i]   = ELEM_NONE;
      if (r_vld[i]) begin
        lane[i] = empty ? w_data : mem[rd_ptr[i]];
      end
    end
  end

  assign r_data_0 = lane[0];
  assign r_data_1 = lane[1];
  assign r_data_2 = lane[2];
  assign r_data_3 = lane[3];

  // ---------------------------------------------------------------------------
  // Occupancy
  // ---------------------------------------------------------------------------
  // One extra bit of headroom; r_cnt never exceeds size + w_acc so the result
  // is never negative, and w_acc is blocked at DEPTH so it never overflows.
  assign size_next = {1'b0, size} + SUM_WIDTH'(w_acc) - SUM_WIDTH'(r_cnt);

  // ---------------------------------------------------------------------------
  // Register update
  // ---------------------------------------------------------------------------
  // A bypassed push is still written at tail; head advances past it in the
  // same edge, so both pointers stay in lock-step with the stored contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      size <= '0;
      full <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= ELEM_NONE;
      end
    end else begin
      if (w_acc) begin
        mem[tail] <= w_data;
        tail      <= tail + PTR_WIDTH'(1);
      end
      head <= head + PTR_WIDTH'(r_cnt);
      size <= size_next[CNT_WIDTH-1:0];
      full <= (size_next == SUM_WIDTH'(FIFO_DEPTH));
    end
  end

endmodule

// File: tb/tb_fifo_4r.sv
// -----------------------------------------------------------------------------
// tb_fifo_4r
//   Self-checking bench for fifo_4r. A queue-based reference model predicts
//   every output each cycle; directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_fifo_4r;

  localparam int W     = 32;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          w_val;
  logic [W-1:0]  w_data;
  logic          w_drop;
  logic [2:0]    r_req;
  logic [W-1:0]  r_data_0, r_data_1, r_data_2, r_data_3;
  logic [3:0]    r_vld;
  logic [2:0]    r_cnt;
  logic [CW-1:0] size;
  logic          full;
  logic          data_avail;

  logic [W-1:0]  lanes [4];
  assign lanes[0] = r_data_0;
  assign lanes[1] = r_data_1;
  assign lanes[2] = r_data_2;
  assign lanes[3] = r_data_3;

  fifo_4r #(.FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .w_val(w_val), .w_data(w_data), .w_drop(w_drop),
    .r_req(r_req), .r_data_0(r_data_0), .r_data_1(r_data_1), .r_data_2(r_data_2),
    .r_data_3(r_data_3), .r_vld(r_vld), .r_cnt(r_cnt), .size(size), .full(full),
    .data_avail(data_avail)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // How many entries the consumer may take right now, from the queue contents
  // and the current inputs.
  function automatic int model_avail();
    int acc;
    acc = (w_val && q.size() < DEPTH) ? 1 : 0;
    if (q.size() == 0) return acc;
    return (q.size() < 4) ? q.size() : 4;
  endfunction

  function automatic int model_cnt();
    int req;
    int av;
    req = (r_req > 3'd4) ? 4 : int'(r_req);
    av  = model_avail();
    return (req < av) ? req : av;
  endfunction

  task automatic model_check();
    int av;
    logic [3:0] ev;
    logic [W-1:0] el;
    av = model_avail();
    ev = 4'b0;
    for (int i = 0; i < 4; i++) ev[i] = (i < av);
    chk("size",       64'(size),       64'(q.size()));
    chk("full",       64'(full),       64'(q.size() == DEPTH));
    chk("w_drop",     64'(w_drop),     64'(w_val && q.size() == DEPTH));
    chk("r_vld",      64'(r_vld),      64'(ev));
    chk("r_cnt",      64'(r_cnt),      64'(model_cnt()));
    chk("data_avail", 64'(data_avail), 64'(av != 0));
    for (int i = 0; i < 4; i++) begin
      if (i >= av)            el = '1;
      else if (q.size() == 0) el = w_data;
      else                    el = q[i];
      chk($sformatf("r_data_%0d", i), 64'(lanes[i]), 64'(el));
    end
  endtask

  // Apply inputs away from the active edge, then check comb/registered outputs.
  task automatic drive(input logic rn, input logic wv, input logic [W-1:0] wd,
                       input logic [2:0] rq);
    @(negedge clk);
    rst_n = rn; w_val = wv; w_data = wd; r_req = rq;
    #1;
    if (rn) model_check();
  endtask

  // Advance one edge and let the model consume the same inputs the DUT saw.
  task automatic tick();
    int n;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
    end else begin
      n = model_cnt();
      if (w_val && q.size() < DEPTH) q.push_back(w_data);
      for (int i = 0; i < n; i++) void'(q.pop_front());
    end
    #1;
  endtask

  logic [W-1:0] nxt;
  int           done;

  initial begin
    rst_n = 1'b0; w_val = 1'b0; w_data = '0; r_req = 3'd0;

    // Reset idle
    drive(0, 0, 0, 0); tick();
    drive(0, 0, 0, 0); tick();
    drive(1, 0, 0, 0);
    chk("t1_size", 64'(size), 64'd0);
    chk("t1_full", 64'(full), 64'd0);
    chk("t1_vld",  64'(r_vld), 64'd0);
    chk("t1_d0",   64'(r_data_0), 64'hFFFF_FFFF);
    chk("t1_d3",   64'(r_data_3), 64'hFFFF_FFFF);
    chk("t1_avail", 64'(data_avail), 64'd0);
    tick();

    // Bypass
    drive(1, 1, 32'hA5, 1);
    chk("t2_d0",  64'(r_data_0), 64'hA5);
    chk("t2_vld", 64'(r_vld), 64'b0001);
    chk("t2_cnt", 64'(r_cnt), 64'd1);
    tick();
    drive(1, 0, 0, 0);
    chk("t2_size", 64'(size), 64'd0);
    tick();

    // Batch pop
    for (int i = 1; i <= 6; i++) begin
      drive(1, 1, W'(i), 0); tick();
    end
    drive(1, 0, 0, 4);
    chk("t3_d0", 64'(r_data_0), 64'd1);
    chk("t3_d1", 64'(r_data_1), 64'd2);
    chk("t3_d2", 64'(r_data_2), 64'd3);
    chk("t3_d3", 64'(r_data_3), 64'd4);
    chk("t3_vld", 64'(r_vld), 64'b1111);
    chk("t3_cnt", 64'(r_cnt), 64'd4);
    tick();
    drive(1, 0, 0, 4);
    chk("t3_d0b", 64'(r_data_0), 64'd5);
    chk("t3_d1b", 64'(r_data_1), 64'd6);
    chk("t3_vldb", 64'(r_vld), 64'b0011);
    chk("t3_cntb", 64'(r_cnt), 64'd2);
    tick();
    drive(1, 0, 0, 0);
    chk("t3_size", 64'(size), 64'd0);
    tick();

    // Full and dropped push
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 32'h100 + W'(i), 0); tick();
    end
    drive(1, 0, 0, 0);
    chk("t4_full", 64'(full), 64'd1);
    chk("t4_size", 64'(size), 64'd16);
    tick();
    drive(1, 1, 32'h99, 0);
    chk("t4_drop", 64'(w_drop), 64'd1);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 4);
      if (k == 0) chk("t4_size_kept", 64'(size), 64'd16);
      for (int i = 0; i < 4; i++)
        chk("t4_order", 64'(lanes[i]), 64'(32'h100 + 4*k + i));
      tick();
    end
    drive(1, 0, 0, 0);
    chk("t4_empty", 64'(size), 64'd0);
    tick();

    // Wrap: stream through with single pops, then drain
    nxt = 32'd1000;
    for (int c = 0; c < 40; c++) begin
      drive(1, 1, 32'd1000 + W'(c), 1);
      for (int j = 0; j < int'(r_cnt); j++) begin
        chk("t5_seq", 64'(lanes[j]), 64'(nxt));
        nxt = nxt + 1;
      end
      tick();
    end
    done = 0;
    for (int c = 0; c < 20 && done == 0; c++) begin
      drive(1, 0, 0, 4);
      if (!data_avail) done = 1;
      for (int j = 0; j < int'(r_cnt); j++) begin
        chk("t5_seq", 64'(lanes[j]), 64'(nxt));
        nxt = nxt + 1;
      end
      tick();
    end
    chk("t5_drained", 64'(done), 64'd1);
    chk("t5_total", 64'(nxt), 64'd1040);

    // Reset mid-operation
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 32'h50 + W'(i), 0); tick();
    end
    drive(1, 0, 0, 0);
    chk("t6_size5", 64'(size), 64'd5);
    tick();
    drive(0, 0, 0, 3); tick();
    drive(1, 0, 0, 0);
    chk("t6_size", 64'(size), 64'd0);
    chk("t6_vld",  64'(r_vld), 64'd0);
    chk("t6_full", 64'(full), 64'd0);
    tick();

    // Randomized traffic, with a bias phase toward filling up
    for (int c = 0; c < 3000; c++) begin
      logic rn;
      logic wv;
      logic [2:0] rq;
      rn = ($urandom_range(0, 199) != 0);
      if ((c / 300) % 2 == 0) begin
        wv = ($urandom_range(0, 9) < 8);
        rq = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      end else begin
        wv = ($urandom_range(0, 9) < 4);
        rq = 3'($urandom_range(0, 7));
      end
      drive(rn, wv, $urandom, rq);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
